adc_buf_reader: RTL



---
 rtl/adc_buf_pkg.sv | 11 +
 rtl/adc_buf_reader_skid.sv | 55 +++++
 rtl/adc_buf_reader.sv | 101 ++++++++++
 3 files changed

// File: rtl/adc_buf_pkg.sv
// Shared types and sizes for the ADC sample buffer read side.
// Optional overrun checking is enabled by ADC_BUF_RD_OVERRUN_CHK_EN.
package adc_buf_pkg;

  localparam int ADC_DATA_W = 12;
  localparam int ADC_ADDR_W = 4;

  typedef logic [ADC_ADDR_W:0]   ptr_t;
  typedef logic [ADC_DATA_W-1:0] sample_t;

endpackage

// File: rtl/adc_buf_reader_skid.sv
// Two-entry valid/ready FIFO that catches SRAM read data.
// Optional overrun checking is enabled by ADC_BUF_RD_OVERRUN_CHK_EN.
module adc_rd_skid
  import adc_buf_pkg::*;
#(
  parameter int W = ADC_DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_idx;
  logic         rd_idx;
  logic         push;
  logic         pop;

  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_idx];
  assign pop       = out_valid && out_ready;
  assign push      = in_valid && ((count != 2'd2) || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_idx <= 1'b0;
      rd_idx <= 1'b0;
      count  <= 2'd0;
    end else if (clr) begin
      wr_idx <= rd_idx;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_idx] <= in_data;
        wr_idx      <= ~wr_idx;
      end
      if (pop)
        rd_idx <= ~rd_idx;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/adc_buf_reader.sv
// Read-side controller for the ADC sample SRAM, streaming over valid/ready.
// Optional overrun checking is enabled by ADC_BUF_RD_OVERRUN_CHK_EN.
module adc_buf_reader
  import adc_buf_pkg::*;
#(
  parameter int DATA_W = ADC_DATA_W,
  parameter int ADDR_W = ADC_ADDR_W,
  parameter int RD_LAT = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W:0]   WR_PTR,
  input  logic              FLUSH,
  output logic [ADDR_W-1:0] RADDR,
  input  logic [DATA_W-1:0] RD,
  output logic [ADDR_W:0]   RD_PTR,
  output logic [DATA_W-1:0] M_DATA,
  output logic              M_VALID,
  input  logic              M_READY,
  output logic              EMPTY,
  output logic              OVERRUN
);

  logic [ADDR_W:0]   rd_ptr;
  logic [RD_LAT-1:0] vld_sr;
  logic [1:0]        infl;
  logic [1:0]        skid_cnt;
  logic [2:0]        outstanding;
  logic              pop;
  logic              credit;
  logic              ovr_block;
  logic              issue;

  assign RD_PTR = rd_ptr;
  assign RADDR  = rd_ptr[ADDR_W-1:0];
  assign EMPTY  = (rd_ptr == WR_PTR);
  assign pop    = M_VALID && M_READY;

  always_comb begin
    infl = 2'd0;
    for (int i = 0; i < RD_LAT; i++)
      infl = infl + 2'(vld_sr[i]);
  end

  // A sample leaving this cycle frees its slot for a new read now.
  assign outstanding = {1'b0, skid_cnt} + {1'b0, infl}
                     - {2'b0, pop};
  assign credit      = (outstanding < 3'd2);

`ifdef ADC_BUF_RD_OVERRUN_CHK_EN
  logic [ADDR_W:0] occ;
  logic            lapped;
  logic            ovr_q;

  assign occ    = WR_PTR - rd_ptr;
  assign lapped = (occ > {1'b1, {ADDR_W{1'b0}}});

  always_ff @(posedge CLK) begin
    if (RST || FLUSH)
      ovr_q <= 1'b0;
    else if (lapped)
      ovr_q <= 1'b1;
  end

  assign OVERRUN   = ovr_q;
  assign ovr_block = ovr_q || lapped;
`else
  assign OVERRUN   = 1'b0;
  assign ovr_block = 1'b0;
`endif

  assign issue = !EMPTY && credit && !ovr_block;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr <= '0;
      vld_sr <= '0;
    end else if (FLUSH) begin
      rd_ptr <= WR_PTR;
      vld_sr <= '0;
    end else begin
      rd_ptr <= rd_ptr + (ADDR_W+1)'(issue);
      vld_sr <= (vld_sr << 1) | RD_LAT'(issue);
    end
  end

  adc_rd_skid #(
    .W (DATA_W)
  ) u_skid (
    .clk       (CLK),
    .rst       (RST),
    .clr       (FLUSH),
    .in_valid  (vld_sr[RD_LAT-1]),
    .in_data   (RD),
    .out_valid (M_VALID),
    .out_ready (M_READY),
    .out_data  (M_DATA),
    .count     (skid_cnt)
  );

endmodule
